// File: rtl/score_datapath.sv
// Score and high-score datapath: 2-digit BCD score, high score,
// and the end-of-game save sequence with its doneSave handshake.
module score_datapath #(
  parameter int SAVE_HOLD = 50_000_000,
  parameter int CNT_W     = 26
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ld_reset,
  input  logic       ld_wait,
  input  logic       ld_one,
  input  logic       ld_ten,
  input  logic       ld_save,
  output logic [3:0] score_ones,
  output logic [3:0] score_tens,
  output logic [3:0] hi_ones,
  output logic [3:0] hi_tens,
  output logic       max_flag,
  output logic       new_high,
  output logic       doneSave
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMP,
    S_SHOW,
    S_DONE,
    S_REL
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST =
    CNT_W'(SAVE_HOLD - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       ones_q, ones_d;
  logic [3:0]       tens_q, tens_d;
  logic [3:0]       hi_ones_q, hi_tens_q;
  logic             carry_q, carry_d;
  logic             max_q, max_d;
  logic             new_high_q;
  logic             done_q;
  logic             clr;
  logic             at_max;
  logic             score_gt;

  assign clr      = ld_reset | (ld_wait & ~ld_save);
  assign at_max   = (tens_q == 4'd9) && (ones_q == 4'd9);
  assign score_gt = {tens_q, ones_q} > {hi_tens_q, hi_ones_q};

  always_comb begin
    ones_d  = ones_q;
    tens_d  = tens_q;
    carry_d = carry_q;
    if (clr) begin
      ones_d  = 4'd0;
      tens_d  = 4'd0;
      carry_d = 1'b0;
    end else if (ld_one) begin
      if (!at_max) begin
        if (ones_q == 4'd9) begin
          ones_d  = 4'd0;
          carry_d = 1'b1;
        end else begin
          ones_d = ones_q + 4'd1;
        end
      end
    end else if (ld_ten && carry_q) begin
      // tens saturates at 9 so the score can never pass 99
      if (tens_q != 4'd9)
        tens_d = tens_q + 4'd1;
      carry_d = 1'b0;
    end
    max_d = ~clr &
      (max_q | ((tens_d == 4'd9) && (ones_d == 4'd9)));
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ones_q  <= 4'd0;
      tens_q  <= 4'd0;
      carry_q <= 1'b0;
      max_q   <= 1'b0;
    end else begin
      ones_q  <= ones_d;
      tens_q  <= tens_d;
      carry_q <= carry_d;
      max_q   <= max_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      hi_ones_q  <= 4'd0;
      hi_tens_q  <= 4'd0;
      new_high_q <= 1'b0;
      done_q     <= 1'b0;
    end else if (ld_reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      new_high_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (ld_save)
            state_q <= S_CMP;
        end
        S_CMP: begin
          if (score_gt) begin
            hi_ones_q  <= ones_q;
            hi_tens_q  <= tens_q;
            new_high_q <= 1'b1;
          end else begin
            new_high_q <= 1'b0;
          end
          cnt_q   <= '0;
          state_q <= S_SHOW;
        end
        S_SHOW: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == HOLD_LAST) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_REL;
        end
        S_REL: begin
          if (!ld_save)
            state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign score_ones = ones_q;
  assign score_tens = tens_q;
  assign hi_ones    = hi_ones_q;
  assign hi_tens    = hi_tens_q;
  assign max_flag   = max_q;
  assign new_high   = new_high_q;
  assign doneSave   = done_q;

endmodule

// File: tb/tb_score_datapath.sv
// Bench for score_datapath: scenario tasks plus random traffic,
// all checked against an integer-score timeline model.
module tb_score_datapath;

  localparam int SH = 4;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       ld_reset = 1'b0;
  logic       ld_wait = 1'b0;
  logic       ld_one = 1'b0;
  logic       ld_ten = 1'b0;
  logic       ld_save = 1'b0;
  logic [3:0] score_ones, score_tens;
  logic [3:0] hi_ones, hi_tens;
  logic       max_flag, new_high, doneSave;

  int total = 0;
  int bad   = 0;

  // model: plain integer score, pending carry, and a save
  // timeline counted in edges since ld_save was sampled (-1 idle)
  int m_s, m_hi, m_age;
  bit m_c, m_max, m_nh;

  score_datapath #(.SAVE_HOLD(SH), .CNT_W(3)) dut (
    .clk(clk), .resetn(resetn),
    .ld_reset(ld_reset), .ld_wait(ld_wait),
    .ld_one(ld_one), .ld_ten(ld_ten), .ld_save(ld_save),
    .score_ones(score_ones), .score_tens(score_tens),
    .hi_ones(hi_ones), .hi_tens(hi_tens),
    .max_flag(max_flag), .new_high(new_high),
    .doneSave(doneSave)
  );

  always #5 clk = ~clk;

  wire [18:0] dv = {score_tens, score_ones, hi_tens, hi_ones,
                    max_flag, new_high, doneSave};

  function automatic logic [18:0] exp_vec();
    return {4'(m_s / 10), 4'(m_s % 10),
            4'(m_hi / 10), 4'(m_hi % 10),
            m_max, m_nh, (m_age == SH + 1)};
  endfunction

  task automatic model_edge(input bit rn, lr, lw, lo, lt, ls);
    if (!rn) begin
      m_s = 0; m_c = 0; m_max = 0; m_nh = 0;
      m_hi = 0; m_age = -1;
      return;
    end
    if (lr) begin
      m_age = -1; m_nh = 0;
    end else if (m_age == -1) begin
      if (ls) m_age = 0;
    end else if (m_age == 0) begin
      if (m_s > m_hi) begin
        m_hi = m_s; m_nh = 1;
      end else m_nh = 0;
      m_age = 1;
    end else if (m_age <= SH + 1) begin
      m_age++;
    end else if (!ls) begin
      m_age = -1;
    end
    if (lr || (lw && !ls)) begin
      m_s = 0; m_c = 0; m_max = 0;
    end else if (lo) begin
      if (m_s < 99) begin
        if (m_s % 10 == 9) begin
          m_s -= 9; m_c = 1;
        end else m_s++;
      end
    end else if (lt && m_c) begin
      if (m_s < 90) m_s += 10;
      m_c = 0;
    end
    if (m_s == 99) m_max = 1;
  endtask

  task automatic step(input bit lr, lw, lo, lt, ls);
    ld_reset = lr; ld_wait = lw;
    ld_one = lo; ld_ten = lt; ld_save = ls;
    @(posedge clk);
    model_edge(resetn, lr, lw, lo, lt, ls);
    #1;
  endtask

  task automatic load_score(input int n);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) begin
      step(0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 0);
    end
  endtask

  task automatic save_full();
    for (int k = 0; k < SH + 3; k++) step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    step(1, 1, 1, 1, 1);
    step(1, 1, 1, 1, 1);
    total++;
    if (dv !== 19'h0) begin
      $display("FAIL reset got=%h exp=0", dv); bad++;
    end
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0);
      total++;
      if (dv !== exp_vec()) begin
        $display("FAIL idle%0d got=%h exp=%h", i, dv, exp_vec());
        bad++;
      end
    end
  endtask

  task automatic test_count();
    step(1, 0, 0, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      step(0, 0, 1, 0, 0);
      total++;
      if (dv !== exp_vec()) begin
        $display("FAIL one%0d got=%h exp=%h", i, dv, exp_vec());
        bad++;
      end
      step(0, 0, 0, 1, 0);
      total++;
      if (dv !== exp_vec()) begin
        $display("FAIL ten%0d got=%h exp=%h", i, dv, exp_vec());
        bad++;
      end
      if (i == 9) begin
        total++;
        if ({score_tens, score_ones} !== 8'h09) begin
          $display("FAIL score09 got=%h exp=09",
                   {score_tens, score_ones});
          bad++;
        end
      end
    end
    total++;
    if ({score_tens, score_ones} !== 8'h10) begin
      $display("FAIL score10 got=%h exp=10",
               {score_tens, score_ones});
      bad++;
    end
  endtask

  task automatic test_saturate();
    step(1, 0, 0, 0, 0);
    for (int i = 1; i <= 120; i++) begin
      step(0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 0);
      total++;
      if (dv !== exp_vec()) begin
        $display("FAIL sat%0d got=%h exp=%h", i, dv, exp_vec());
        bad++;
      end
    end
    total++;
    if ({score_tens, score_ones, max_flag} !== 9'h133) begin
      $display("FAIL sat99 got=%h exp=133",
               {score_tens, score_ones, max_flag});
      bad++;
    end
  endtask

  task automatic test_save_new_high();
    load_score(30);
    save_full();
    load_score(42);
    for (int k = 0; k < SH + 4; k++) begin
      step(0, 0, 0, 0, 1);
      total++;
      if (dv !== exp_vec()) begin
        $display("FAIL nh_k%0d got=%h exp=%h", k, dv, exp_vec());
        bad++;
      end
      total++;
      if (doneSave !== (k == SH + 1)) begin
        $display("FAIL nh_done_k%0d got=%b exp=%b",
                 k, doneSave, (k == SH + 1));
        bad++;
      end
      if (k == 1) begin
        total++;
        if ({hi_tens, hi_ones, new_high} !== 9'h085) begin
          $display("FAIL nh_hi got=%h exp=085",
                   {hi_tens, hi_ones, new_high});
          bad++;
        end
      end
    end
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
  endtask

  task automatic test_save_equal();
    resetn = 1'b0;
    step(0, 0, 0, 0, 0);
    resetn = 1'b1;
    load_score(30);
    save_full();
    load_score(30);
    for (int k = 0; k < SH + 4; k++) begin
      step(0, 0, 0, 0, 1);
      total++;
      if (dv !== exp_vec()) begin
        $display("FAIL eq_k%0d got=%h exp=%h", k, dv, exp_vec());
        bad++;
      end
      total++;
      if (doneSave !== (k == SH + 1)) begin
        $display("FAIL eq_done_k%0d got=%b exp=%b",
                 k, doneSave, (k == SH + 1));
        bad++;
      end
    end
    total++;
    if ({hi_tens, hi_ones, new_high} !== 9'h060) begin
      $display("FAIL eq_hi got=%h exp=060",
               {hi_tens, hi_ones, new_high});
      bad++;
    end
    step(0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid_save();
    load_score(55);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    total++;
    if ({score_tens, score_ones, hi_tens, hi_ones, new_high}
        !== 17'h00AA) begin
      $display("FAIL mid_rst got=%h exp=00aa",
               {score_tens, score_ones, hi_tens, hi_ones, new_high});
      bad++;
    end
    for (int k = 0; k < SH + 4; k++) begin
      step(0, 0, 0, 0, 0);
      total++;
      if (dv !== exp_vec() || doneSave !== 1'b0) begin
        $display("FAIL mid_k%0d got=%h exp=%h", k, dv, exp_vec());
        bad++;
      end
    end
  endtask

  task automatic test_random();
    bit ls = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) ls = ~ls;
      step($urandom_range(63) == 0, $urandom_range(39) == 0,
           $urandom_range(1) == 1, $urandom_range(1) == 1, ls);
      total++;
      if (dv !== exp_vec()) begin
        $display("FAIL rnd%0d got=%h exp=%h", i, dv, exp_vec());
        bad++;
      end
    end
  endtask

  initial begin
    m_s = 0; m_c = 0; m_max = 0; m_nh = 0;
    m_hi = 0; m_age = -1;
    test_reset();
    test_count();
    test_saturate();
    test_save_new_high();
    test_save_equal();
    test_reset_mid_save();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
